// File: rtl/lift_pkg.sv
// lift_pkg: definitions shared by the lift controller and the car executor.
//   action_e  : command encoding carried on the Action bus
//   FLOOR_W   : width of a floor number
//   TOP_FLOOR : highest floor index (4th floor)
package lift_pkg;

    localparam int unsigned FLOOR_W = 2;
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = 2'd3;

    typedef enum logic [1:0] {
        ACT_UP   = 2'd0,
        ACT_DOWN = 2'd1,
        ACT_STAY = 2'd2,
        ACT_HOME = 2'd3
    } action_e;

endpackage

// File: rtl/lift_cycle_timer.sv
// lift_cycle_timer: 8-bit loadable down-counter.
//   Clock, Reset : system clock, synchronous active-high reset (count -> 0)
//   load         : load load_value on the next edge (wins over counting)
//   load_value   : value to load
//   count        : current count
//   zero         : count == 0; the counter holds at 0 until reloaded
module lift_cycle_timer (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [7:0] count,
    output logic       zero
);

    logic [7:0] count_d;
    logic [7:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/lift_car_executor.sv
// lift_car_executor: executes one command at a time for a 4-floor lift car.
//   Clock, Reset : system clock, synchronous active-high reset
//   Action       : command (Up / Down / Stay / Reset-home), sampled only when Ready
//   Ready        : idle, Action sampled on this cycle's rising edge
//   Floor        : current floor 0..3
//   Moving       : car between floors; Direction 1 = up, 0 = down
//   DoorOpen     : door open at Floor
//   Arrived      : one-cycle pulse on every floor change
//   Fault        : sticky illegal-command flag, cleared only by Reset
//   TripCount    : saturating count of completed one-floor hops
// All outputs are registered; the flag outputs are decoded from the next state.
module lift_car_executor
    import lift_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [1:0]         Action,
    output logic               Ready,
    output logic [FLOOR_W-1:0] Floor,
    output logic               Moving,
    output logic               Direction,
    output logic               DoorOpen,
    output logic               Arrived,
    output logic               Fault,
    output logic [7:0]         TripCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_HOMING,
        S_DOOR,
        S_FAULT
    } state_e;

    localparam logic [7:0] HOP_LOAD  = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] DOOR_LOAD = 8'(DOOR_CYCLES - 1);

    state_e             state_d, state_q;
    logic [FLOOR_W-1:0] floor_d, floor_q;
    logic [7:0]         trip_d, trip_q;
    logic               arrived_d, arrived_q;
    logic               ready_d, ready_q;
    logic               moving_d, moving_q;
    logic               direction_d, direction_q;
    logic               door_open_d, door_open_q;
    logic               fault_d, fault_q;

    logic       hop_load, door_load;
    logic       hop_zero, door_zero;
    logic [7:0] hop_count, door_count;

    lift_cycle_timer u_hop_timer (
        .Clock      (Clock),
        .Reset      (Reset),
        .load       (hop_load),
        .load_value (HOP_LOAD),
        .count      (hop_count),
        .zero       (hop_zero)
    );

    lift_cycle_timer u_door_timer (
        .Clock      (Clock),
        .Reset      (Reset),
        .load       (door_load),
        .load_value (DOOR_LOAD),
        .count      (door_count),
        .zero       (door_zero)
    );

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        trip_d    = trip_q;
        arrived_d = 1'b0;
        hop_load  = 1'b0;
        door_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                case (action_e'(Action))
                    ACT_UP: begin
                        if (floor_q != TOP_FLOOR) begin
                            state_d  = S_MOVE_UP;
                            hop_load = 1'b1;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end
                    ACT_DOWN: begin
                        if (floor_q != '0) begin
                            state_d  = S_MOVE_DOWN;
                            hop_load = 1'b1;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end
                    ACT_HOME: begin
                        if (floor_q != '0) begin
                            state_d  = S_HOMING;
                            hop_load = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_MOVE_UP: begin
                if (hop_zero) begin
                    floor_d   = floor_q + 1'b1;
                    arrived_d = 1'b1;
                    trip_d    = (trip_q == 8'hFF) ? trip_q : trip_q + 8'd1;
                    state_d   = S_DOOR;
                    door_load = 1'b1;
                end
            end
            S_MOVE_DOWN, S_HOMING: begin
                if (hop_zero) begin
                    floor_d   = floor_q - 1'b1;
                    arrived_d = 1'b1;
                    trip_d    = (trip_q == 8'hFF) ? trip_q : trip_q + 8'd1;
                    // Homing reloads the hop timer in the same edge so Moving
                    // never drops between chained hops.
                    if (state_q == S_HOMING && floor_q != 2'd1) begin
                        hop_load = 1'b1;
                    end else begin
                        state_d   = S_DOOR;
                        door_load = 1'b1;
                    end
                end
            end
            S_DOOR: begin
                if (door_zero) begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: ;
            default: state_d = S_IDLE;
        endcase

        ready_d     = (state_d == S_IDLE);
        moving_d    = (state_d == S_MOVE_UP) || (state_d == S_MOVE_DOWN) ||
                      (state_d == S_HOMING);
        direction_d = (state_d == S_MOVE_UP);
        door_open_d = (state_d == S_DOOR);
        fault_d     = (state_d == S_FAULT);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            floor_q     <= '0;
            trip_q      <= '0;
            arrived_q   <= 1'b0;
            ready_q     <= 1'b1;
            moving_q    <= 1'b0;
            direction_q <= 1'b0;
            door_open_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            trip_q      <= trip_d;
            arrived_q   <= arrived_d;
            ready_q     <= ready_d;
            moving_q    <= moving_d;
            direction_q <= direction_d;
            door_open_q <= door_open_d;
            fault_q     <= fault_d;
        end
    end

    assign Ready     = ready_q;
    assign Floor     = floor_q;
    assign Moving    = moving_q;
    assign Direction = direction_q;
    assign DoorOpen  = door_open_q;
    assign Arrived   = arrived_q;
    assign Fault     = fault_q;
    assign TripCount = trip_q;

endmodule

// File: tb/tb_lift_car_executor.sv
// tb_lift_car_executor: scoreboard bench for lift_car_executor.
// The stimulus process issues commands whenever the car is idle and, for
// each command, pushes one expected output record per clock cycle of the
// response, derived from the floor/hop/door rules. A separate monitor pops
// one record per cycle on the falling edge and compares every output.
module tb_lift_car_executor;

    localparam int unsigned T = 4;
    localparam int unsigned D = 3;

    logic       Clock;
    logic       Reset;
    logic [1:0] Action;
    logic       Ready;
    logic [1:0] Floor;
    logic       Moving;
    logic       Direction;
    logic       DoorOpen;
    logic       Arrived;
    logic       Fault;
    logic [7:0] TripCount;

    lift_car_executor #(
        .TRAVEL_CYCLES (T),
        .DOOR_CYCLES   (D)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Action    (Action),
        .Ready     (Ready),
        .Floor     (Floor),
        .Moving    (Moving),
        .Direction (Direction),
        .DoorOpen  (DoorOpen),
        .Arrived   (Arrived),
        .Fault     (Fault),
        .TripCount (TripCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       ready;
        logic [1:0] floor;
        logic       moving;
        logic       dir;
        logic       door;
        logic       arrived;
        logic       fault;
        logic [7:0] trips;
    } exp_t;

    exp_t  q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "init";

    // reference model state
    int    m_floor;
    int    m_trips;
    bit    m_fault;

    function automatic exp_t mk(bit r, int f, bit mv, bit dr, bit dor, bit arr,
                                bit flt, int tr);
        exp_t e;
        e.ready   = r;
        e.floor   = 2'(f);
        e.moving  = mv;
        e.dir     = dr;
        e.door    = dor;
        e.arrived = arr;
        e.fault   = flt;
        e.trips   = 8'(tr);
        return e;
    endfunction

    // monitor / scoreboard
    always @(negedge Clock) begin
        if (q.size() != 0) begin
            exp_t e;
            bit   ok;
            e  = q.pop_front();
            ok = (Ready == e.ready) && (Floor == e.floor) && (Moving == e.moving) &&
                 (!e.moving || Direction == e.dir) && (DoorOpen == e.door) &&
                 (Arrived == e.arrived) && (Fault == e.fault) && (TripCount == e.trips);
            n_checks++;
            if (ok) begin
                n_pass++;
            end else begin
                $display("FAIL %s t=%0t got rdy=%b fl=%0d mv=%b dir=%b door=%b arr=%b flt=%b trips=%0d expected rdy=%b fl=%0d mv=%b dir=%b door=%b arr=%b flt=%b trips=%0d",
                         phase, $time, Ready, Floor, Moving, Direction, DoorOpen,
                         Arrived, Fault, TripCount, e.ready, e.floor, e.moving,
                         e.dir, e.door, e.arrived, e.fault, e.trips);
            end
        end
    end

    // Wait until every expected record has been compared; Action is
    // scrambled meanwhile because the car must ignore it while busy.
    task automatic drain();
        int unsigned budget;
        budget = 0;
        do begin
            @(posedge Clock);
            #1;
            budget++;
            if (q.size() != 0) Action = 2'($urandom_range(0, 3));
        end while (q.size() != 0 && budget < 400);
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL %s drain timeout got %0d records pending expected 0",
                     phase, q.size());
            q.delete();
        end
    endtask

    // cur describes the outputs of the cycle in which Reset is raised.
    task automatic do_reset(input exp_t cur);
        Reset = 1'b1;
        q.push_back(cur);
        @(posedge Clock);
        #1;
        Reset   = 1'b0;
        m_floor = 0;
        m_trips = 0;
        m_fault = 1'b0;
    endtask

    task automatic issue(input logic [1:0] a);
        int unsigned nhops;
        int          step;
        bit          dir;
        bit          arr;
        Action = a;
        q.push_back(mk(1, m_floor, 0, 0, 0, 0, 0, m_trips));
        nhops = 0;
        step  = 0;
        dir   = 1'b0;
        case (a)
            2'd0: if (m_floor == 3) m_fault = 1'b1;
                  else begin nhops = 1; step = 1; dir = 1'b1; end
            2'd1: if (m_floor == 0) m_fault = 1'b1;
                  else begin nhops = 1; step = -1; end
            2'd3: begin nhops = m_floor; step = -1; end
            default: ;
        endcase
        if (m_fault) begin
            for (int k = 0; k < 21; k++)
                q.push_back(mk(0, m_floor, 0, 0, 0, 0, 1, m_trips));
        end
        arr = 1'b0;
        for (int unsigned h = 0; h < nhops; h++) begin
            for (int unsigned i = 0; i < T; i++)
                q.push_back(mk(0, m_floor, 1, dir, 0, (i == 0) && arr, 0, m_trips));
            arr     = 1'b1;
            m_floor = m_floor + step;
            if (m_trips < 255) m_trips++;
        end
        if (nhops > 0) begin
            for (int unsigned j = 0; j < D; j++)
                q.push_back(mk(0, m_floor, 0, 0, 1, j == 0, 0, m_trips));
        end
        drain();
    endtask

    task automatic clear_fault();
        do_reset(mk(0, m_floor, 0, 0, 0, 0, 1, m_trips));
    endtask

    initial begin
        Reset   = 1'b1;
        Action  = 2'd2;
        m_floor = 0;
        m_trips = 0;
        m_fault = 1'b0;
        @(posedge Clock);
        #1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        phase = "up_from_0";
        issue(2'd0);

        phase = "down_at_0_fault";
        do_reset(mk(1, m_floor, 0, 0, 0, 0, 0, m_trips));
        issue(2'd1);
        clear_fault();

        phase = "climb_to_3";
        repeat (3) issue(2'd0);
        phase = "homing_from_3";
        issue(2'd3);

        phase = "up_at_3_fault";
        repeat (3) issue(2'd0);
        issue(2'd0);
        clear_fault();

        phase = "reset_mid_hop";
        issue(2'd0);
        Action = 2'd0;
        q.push_back(mk(1, m_floor, 0, 0, 0, 0, 0, m_trips));
        q.push_back(mk(0, m_floor, 1, 1, 0, 0, 0, m_trips));
        drain();
        do_reset(mk(0, m_floor, 1, 1, 0, 0, 0, m_trips));
        issue(2'd2);
        issue(2'd3);

        phase = "random";
        repeat (150) begin
            issue(2'($urandom_range(0, 3)));
            if (m_fault) clear_fault();
        end

        phase = "saturate";
        do_reset(mk(1, m_floor, 0, 0, 0, 0, 0, m_trips));
        repeat (130) begin
            issue(2'd0);
            issue(2'd1);
        end
        issue(2'd2);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
